// File: rtl/sr_btn_pulse_gen_if.sv
// Button inputs and conditioned command outputs of the SR button pulse generator.
// The master drives the raw buttons, and the slave (the conditioner) drives the pulses, levels and count.
interface sr_btn_pulse_gen_if #(
  parameter int CNT_W = 8
);
  logic             set_btn;
  logic             clr_btn;
  logic             S;
  logic             R;
  logic             set_lvl;
  logic             clr_lvl;
  logic [CNT_W-1:0] set_cnt;

  modport master (
    output set_btn, clr_btn,
    input  S, R, set_lvl, clr_lvl, set_cnt
  );

  modport slave (
    input  set_btn, clr_btn,
    output S, R, set_lvl, clr_lvl, set_cnt
  );
endinterface

// File: rtl/sr_btn_pulse_gen.sv
// Synchronises, debounces and edge-detects the set/clear buttons into one-cycle S/R
// pulses for a downstream SR flop, with debounced levels and a count of issued S pulses.
module sr_btn_pulse_gen #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  sr_btn_pulse_gen_if.slave bus
);

  localparam int            DW      = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  // Channel 0 is set, channel 1 is clear.
  logic [1:0]       raw;
  logic [1:0]       s1_q, s2_q;
  logic [1:0]       lvl_q, lvl_d;
  logic [1:0]       rise;
  logic [DW-1:0]    dcnt_q [2];
  logic [DW-1:0]    dcnt_d [2];
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign raw = {bus.clr_btn, bus.set_btn};

  always_comb begin
    lvl_d = lvl_q;
    rise  = '0;
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i] = '0;
      if (s2_q[i] != lvl_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          lvl_d[i] = s2_q[i];
          rise[i]  = s2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
    // A clear rising on the same edge wins; the set event is dropped outright.
    r_d   = rise[1];
    s_d   = rise[0] & ~rise[1];
    cnt_d = cnt_q + CNT_W'(s_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= '0;
      s_q   <= 1'b0;
      r_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= dcnt_d[i];
      s_q   <= s_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.S       = s_q;
  assign bus.R       = r_q;
  assign bus.set_lvl = lvl_q[0];
  assign bus.clr_lvl = lvl_q[1];
  assign bus.set_cnt = cnt_q;

endmodule
